// File: rtl/edge_event_scheduler.sv
// Per-channel rising/falling edge detector with pending-event latches and a round-robin
// arbiter feeding one registered valid/ready event stream. Optional macro: EDGE_SYNC_EN.
module edge_event_scheduler #(
  parameter  int N  = 4,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  in,
  input  logic [N-1:0]  rise_en,
  input  logic [N-1:0]  fall_en,
  output logic          evt_valid,
  input  logic          evt_ready,
  output logic [CW-1:0] evt_chan,
  output logic          evt_rising,
  output logic          evt_overrun
);

  logic [N-1:0] in_s;
  logic         load_done;

`ifdef EDGE_SYNC_EN
  logic [N-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]   ld_cnt_q, ld_cnt_d;

  // Priming is held off until both synchroniser stages hold real samples.
  always_comb begin
    sync1_d  = in;
    sync2_d  = sync1_q;
    ld_cnt_d = (ld_cnt_q == 2'd2) ? ld_cnt_q : ld_cnt_q + 2'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      ld_cnt_q <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      ld_cnt_q <= ld_cnt_d;
    end
  end

  assign in_s      = sync2_q;
  assign load_done = (ld_cnt_q == 2'd2);
`else
  assign in_s      = in;
  assign load_done = 1'b1;
`endif

  logic [N-1:0]  in_q_q, in_q_d;
  logic          primed_q, primed_d;
  logic [N-1:0]  pend_q, pend_d, pend_pol_q, pend_pol_d, ovr_q, ovr_d;
  logic [CW-1:0] rr_ptr_q, rr_ptr_d;
  logic          evt_valid_q, evt_valid_d;
  logic [CW-1:0] evt_chan_q, evt_chan_d;
  logic          evt_rising_q, evt_rising_d;
  logic          evt_overrun_q, evt_overrun_d;

  logic [N-1:0]  rise, fall, edge_any;
  logic          slot_free, gnt_any, hi_found;
  logic [CW-1:0] gnt_idx, hi_idx, lo_idx;

  always_comb begin
    rise      = primed_q ? (~in_q_q &  in_s & rise_en) : '0;
    fall      = primed_q ? ( in_q_q & ~in_s & fall_en) : '0;
    edge_any  = rise | fall;
    in_q_d    = in_s;
    primed_d  = primed_q | load_done;
    slot_free = ~evt_valid_q | evt_ready;
  end

  // Descending scan leaves the lowest pending index at/above rr_ptr in hi_idx,
  // and the lowest one below it in lo_idx for the wrap-around case.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        if (CW'(i) >= rr_ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = CW'(i);
        end else begin
          lo_idx = CW'(i);
        end
      end
    end
    gnt_any = slot_free & (|pend_q);
    gnt_idx = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    pend_d        = pend_q;
    pend_pol_d    = pend_pol_q;
    ovr_d         = ovr_q;
    rr_ptr_d      = rr_ptr_q;
    evt_valid_d   = evt_valid_q;
    evt_chan_d    = evt_chan_q;
    evt_rising_d  = evt_rising_q;
    evt_overrun_d = evt_overrun_q;

    for (int i = 0; i < N; i++) begin
      if (edge_any[i]) begin
        pend_d[i]     = 1'b1;
        pend_pol_d[i] = rise[i];
        ovr_d[i]      = pend_q[i] & ~(gnt_any && (gnt_idx == CW'(i)));
      end else if (gnt_any && (gnt_idx == CW'(i))) begin
        pend_d[i] = 1'b0;
        ovr_d[i]  = 1'b0;
      end
    end

    if (slot_free) begin
      evt_valid_d = gnt_any;
      if (gnt_any) begin
        evt_chan_d    = gnt_idx;
        evt_rising_d  = pend_pol_q[gnt_idx];
        evt_overrun_d = ovr_q[gnt_idx];
        rr_ptr_d      = (gnt_idx == CW'(N - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_q_q        <= '0;
      primed_q      <= 1'b0;
      pend_q        <= '0;
      pend_pol_q    <= '0;
      ovr_q         <= '0;
      rr_ptr_q      <= '0;
      evt_valid_q   <= 1'b0;
      evt_chan_q    <= '0;
      evt_rising_q  <= 1'b0;
      evt_overrun_q <= 1'b0;
    end else begin
      in_q_q        <= in_q_d;
      primed_q      <= primed_d;
      pend_q        <= pend_d;
      pend_pol_q    <= pend_pol_d;
      ovr_q         <= ovr_d;
      rr_ptr_q      <= rr_ptr_d;
      evt_valid_q   <= evt_valid_d;
      evt_chan_q    <= evt_chan_d;
      evt_rising_q  <= evt_rising_d;
      evt_overrun_q <= evt_overrun_d;
    end
  end

  assign evt_valid   = evt_valid_q;
  assign evt_chan    = evt_chan_q;
  assign evt_rising  = evt_rising_q;
  assign evt_overrun = evt_overrun_q;

endmodule

// File: tb/tb_edge_event_scheduler.sv
// Directed bench for edge_event_scheduler (N=4): expected events are queued as edges are
// driven and popped on each accepted handshake.
module tb_edge_event_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_l, rise_en, fall_en;
  logic       evt_valid, evt_ready, evt_rising, evt_overrun;
  logic [1:0] evt_chan;

  typedef struct packed {
    logic [1:0] chan;
    logic       rising;
    logic       ovr;
  } evt_t;

  evt_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  edge_event_scheduler #(.N(4)) dut (
    .clk(clk), .reset(reset), .in(in_l), .rise_en(rise_en), .fall_en(fall_en),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_chan(evt_chan),
    .evt_rising(evt_rising), .evt_overrun(evt_overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] c, input logic r, input logic o);
    evt_t e;
    e.chan = c; e.rising = r; e.ovr = o;
    sb.push_back(e);
  endtask

  // Outputs and evt_ready are stable here; a handshake now is the one the next posedge takes.
  task automatic cyc();
    evt_t e;
    if (evt_valid && evt_ready) begin
      chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("evt_chan", 32'(evt_chan), 32'(e.chan));
        chk("evt_rising", 32'(evt_rising), 32'(e.rising));
        chk("evt_overrun", 32'(evt_overrun), 32'(e.ovr));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic expect_valid(input logic v);
    chk("evt_valid", 32'(evt_valid), 32'(v));
    cyc();
  endtask

  task automatic quiet(input string tag, input int n);
    int cnt = 0;
    for (int k = 0; k < n; k++) begin
      if (evt_valid) cnt++;
      cyc();
    end
    chk(tag, 32'(cnt), 32'd0);
  endtask

  task automatic hold_ch0();
    chk("hold_valid", 32'(evt_valid), 32'd1);
    chk("hold_chan", 32'(evt_chan), 32'd0);
    chk("hold_rising", 32'(evt_rising), 32'd1);
    chk("hold_ovr", 32'(evt_overrun), 32'd0);
  endtask

  initial begin
    reset = 1'b1; in_l = 4'b1111; rise_en = 4'b1111; fall_en = 4'b1111; evt_ready = 1'b1;
    #1;
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_chan", 32'(evt_chan), 32'd0);
    chk("rst_rising", 32'(evt_rising), 32'd0);
    chk("rst_ovr", 32'(evt_overrun), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Lines high at release must not produce events
    reset = 1'b0;
    quiet("prime_quiet", 20);
    fall_en = 4'b0000; in_l = 4'b0000;
    quiet("masked_fall_quiet", 3);
    fall_en = 4'b1111;

    // Single rising edge on ch2: exact latency and one-cycle pulse
    in_l = 4'b0100; push(2'd2, 1'b1, 1'b0);
    cyc();
    expect_valid(1'b0);
    expect_valid(1'b1);
    expect_valid(1'b0);
    expect_valid(1'b0);

    // Fresh reset so rr_ptr starts at 0
    reset = 1'b1; in_l = 4'b0000;
    cyc(); cyc();
    reset = 1'b0;
    cyc(); cyc();

    in_l = 4'b1011;
    push(2'd0, 1'b1, 1'b0); push(2'd1, 1'b1, 1'b0); push(2'd3, 1'b1, 1'b0);
    cyc();
    expect_valid(1'b0);
    expect_valid(1'b1); expect_valid(1'b1); expect_valid(1'b1);
    expect_valid(1'b0);

    in_l = 4'b0010;
    push(2'd0, 1'b0, 1'b0); push(2'd3, 1'b0, 1'b0);
    cyc();
    expect_valid(1'b0);
    expect_valid(1'b1); expect_valid(1'b1);
    expect_valid(1'b0);

    // rr_ptr must have wrapped to 0: 0 before 3 again
    in_l = 4'b1011;
    push(2'd0, 1'b1, 1'b0); push(2'd3, 1'b1, 1'b0);
    cyc();
    expect_valid(1'b0);
    expect_valid(1'b1); expect_valid(1'b1);
    expect_valid(1'b0);

    in_l = 4'b0000;
    push(2'd0, 1'b0, 1'b0); push(2'd1, 1'b0, 1'b0); push(2'd3, 1'b0, 1'b0);
    cyc();
    expect_valid(1'b0);
    expect_valid(1'b1); expect_valid(1'b1); expect_valid(1'b1);
    expect_valid(1'b0);

    // Stall with ch0 in the slot while ch1 rises then falls (merged)
    evt_ready = 1'b0;
    in_l = 4'b0001; push(2'd0, 1'b1, 1'b0);
    cyc();
    expect_valid(1'b0);
    hold_ch0();
    in_l = 4'b0011;
    cyc();
    hold_ch0();
    cyc();
    hold_ch0();
    in_l = 4'b0001; push(2'd1, 1'b0, 1'b1);
    cyc();
    hold_ch0();
    evt_ready = 1'b1;
    cyc();
    expect_valid(1'b1);
    expect_valid(1'b0);

    // Falling edges masked: ch1 pulse yields only the rising event
    fall_en = 4'b0000;
    in_l = 4'b0011; push(2'd1, 1'b1, 1'b0);
    cyc();
    in_l = 4'b0001;
    expect_valid(1'b0);
    expect_valid(1'b1);
    expect_valid(1'b0);
    expect_valid(1'b0);
    fall_en = 4'b1111;

    // Reset while an event is in the slot and ch2 is pending
    evt_ready = 1'b0;
    in_l = 4'b0000;
    cyc();
    expect_valid(1'b0);
    in_l = 4'b0100;
    chk("pre_rst_valid", 32'(evt_valid), 32'd1);
    cyc();
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(evt_valid), 32'd0);
    chk("mid_rst_chan", 32'(evt_chan), 32'd0);
    chk("mid_rst_rising", 32'(evt_rising), 32'd0);
    chk("mid_rst_ovr", 32'(evt_overrun), 32'd0);
    cyc(); cyc();
    reset = 1'b0; evt_ready = 1'b1;
    quiet("post_rst_quiet", 20);

    in_l = 4'b0000; push(2'd2, 1'b0, 1'b0);
    cyc();
    expect_valid(1'b0);
    expect_valid(1'b1);
    expect_valid(1'b0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
